wb_port_arbiter: RTL and testbench

- Schedules the single register-file write port between the in-order pipeline writeback (stage 5 result, already muxed by its WB select) and the out-of-order multi-cycle mult/div unit's GPR results.
- Pipeline WB has priority. Mult/div results wait in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so the oldest buffered result can drain.
- Sits between the stage-5 result mux and the register file; drives the pipeline stall request.

---
 rtl/wb_port_arbiter_if.sv | 26 ++
 rtl/wb_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bus between the stage-5 writeback, the mult/div
// result channel and the register file. The master side is the producer
// (pipeline + mult/div); the slave side is the arbiter.
interface wb_port_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        stall_wb;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
        input  md_ready, stall_wb, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
        output md_ready, stall_wb, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline writeback (priority) and buffered mult/div results.
// A wait counter forces a one-cycle pipeline stall so the FIFO head drains.
// Pipeline writes invalidate same-address FIFO entries (the pipeline value is
// newer). Optional performance counters are enabled with WB_ARB_PERF_EN.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_port_arbiter_if.slave bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [15:0] conflict_cnt,
    output logic [15:0] force_cnt
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t         state_r, state_next_s;
    logic [3:0]     wait_r, wait_next_s;
    logic [CW-1:0]  count_r, count_next_s;
    logic [AW-1:0]  rd_ptr_r, wr_ptr_r;
    logic [4:0]     addr_r [DEPTH];
    logic [31:0]    data_r [DEPTH];
    logic           vld_r  [DEPTH];

    logic           wb_wr_s, wb_win_s, pop_s, push_s, store_s;
    logic           md_ready_s, stall_s, head_vld_s;
    logic           rf_we_r;
    logic [4:0]     rf_waddr_r;
    logic [31:0]    rf_wdata_r;

    // Arbitration, FIFO handshake, wait counter and next-state decode.
    always_comb begin
        wb_wr_s      = bus.wb_valid && (bus.wb_addr != 5'd0);
        wb_win_s     = 1'b0;
        pop_s        = 1'b0;
        stall_s      = 1'b0;
        wait_next_s  = 4'd0;
        state_next_s = state_r;
        head_vld_s   = vld_r[rd_ptr_r];

        case (state_r)
            IDLE: begin
                wb_win_s = wb_wr_s;
            end
            PEND: begin
                if (wb_wr_s) begin
                    wb_win_s = 1'b1;
                end else begin
                    pop_s = (count_r != CW'(0));
                end
            end
            FORCE: begin
                pop_s   = (count_r != CW'(0));
                stall_s = 1'b1;
            end
            default: begin
                wb_win_s = 1'b0;
            end
        endcase

        // Full FIFO still accepts when the head leaves this same cycle.
        md_ready_s   = (count_r != CW'(DEPTH)) || pop_s;
        push_s       = bus.md_valid && md_ready_s;
        store_s      = push_s && (bus.md_addr != 5'd0);
        count_next_s = count_r + CW'(store_s) - CW'(pop_s);

        // Count blocked cycles only while the pipeline is beating the head.
        if ((state_r == PEND) && wb_win_s) begin
            if (wait_r == 4'(MAX_WAIT)) begin
                wait_next_s = wait_r;
            end else begin
                wait_next_s = wait_r + 4'd1;
            end
        end else begin
            wait_next_s = 4'd0;
        end

        case (state_r)
            IDLE: begin
                if (store_s) begin
                    state_next_s = PEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PEND: begin
                if (count_next_s == CW'(0)) begin
                    state_next_s = IDLE;
                end else if (wait_next_s == 4'(MAX_WAIT)) begin
                    state_next_s = FORCE;
                end else begin
                    state_next_s = PEND;
                end
            end
            FORCE: begin
                if (count_next_s == CW'(0)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, wait counter, occupancy and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            wait_r   <= 4'd0;
            count_r  <= CW'(0);
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
        end else begin
            state_r <= state_next_s;
            wait_r  <= wait_next_s;
            count_r <= count_next_s;
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
        end
    end

    // Entry valid bits: pipeline writes kill older same-address entries,
    // while a push in the same cycle is newer and stays valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_win_s && vld_r[i] && (addr_r[i] == bus.wb_addr)) begin
                    vld_r[i] <= 1'b0;
                end
            end
            if (store_s) begin
                vld_r[wr_ptr_r] <= 1'b1;
            end
        end
    end

    // FIFO payload storage; contents only matter while the valid bit is set.
    always_ff @(posedge clk) begin
        if (store_s) begin
            addr_r[wr_ptr_r] <= bus.md_addr;
            data_r[wr_ptr_r] <= bus.md_data;
        end
    end

    // Registered write port: pipeline winner first, else a valid popped head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= 32'd0;
        end else if (wb_win_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= bus.wb_addr;
            rf_wdata_r <= bus.wb_data;
        end else if (pop_s && head_vld_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= addr_r[rd_ptr_r];
            rf_wdata_r <= data_r[rd_ptr_r];
        end else begin
            rf_we_r <= 1'b0;
        end
    end

`ifdef WB_ARB_PERF_EN
    // Performance counters: pipeline/FIFO conflicts and forced drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= 16'd0;
            force_cnt    <= 16'd0;
        end else begin
            if (bus.wb_valid && (count_r != CW'(0))) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (state_r == FORCE) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end
`endif

    assign bus.md_ready = md_ready_s;
    assign bus.stall_wb = stall_s;
    assign bus.rf_we    = rf_we_r;
    assign bus.rf_waddr = rf_waddr_r;
    assign bus.rf_wdata = rf_wdata_r;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4).
// Inputs change 1 ns after the rising edge; combinational outputs are
// checked before the next edge, registered outputs 1 ns after it.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    wb_port_arbiter_if bus();

`ifdef WB_ARB_PERF_EN
    logic [15:0] conflict_cnt;
    logic [15:0] force_cnt;
`endif

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.wb_valid = wv;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.md_valid = mv;
        bus.md_addr  = ma;
        bus.md_data  = md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held 2 cycles with both requesters active.
        drv(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44);
        tick();
        tick();
        chk("rst_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("rst_wdata", bus.rf_wdata, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_wb}, 32'd0);
        chk("rst_ready", {31'd0, bus.md_ready}, 32'd1);
        rst_n = 1'b1;
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("rst_empty_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst_empty_ready", {31'd0, bus.md_ready}, 32'd1);

        // Single push then drain with no pipeline traffic.
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD);
        tick();
        chk("push_we", {31'd0, bus.rf_we}, 32'd0);
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("pop_we", {31'd0, bus.rf_we}, 32'd1);
        chk("pop_waddr", {27'd0, bus.rf_waddr}, 32'd5);
        chk("pop_wdata", bus.rf_wdata, 32'hDEAD);
        tick();
        chk("pop_after_we", {31'd0, bus.rf_we}, 32'd0);

        // Starvation: r7 buffered, pipeline writes r3 every cycle.
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 5'd3, 32'h300 + 32'(i), 1'b0, 5'd0, 32'd0);
            chk("starve_stall0", {31'd0, bus.stall_wb}, 32'd0);
            tick();
            chk("starve_we", {31'd0, bus.rf_we}, 32'd1);
            chk("starve_waddr", {27'd0, bus.rf_waddr}, 32'd3);
            chk("starve_wdata", bus.rf_wdata, 32'h300 + 32'(i));
        end
        drv(1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0);
        chk("force_stall", {31'd0, bus.stall_wb}, 32'd1);
        tick();
        chk("force_we", {31'd0, bus.rf_we}, 32'd1);
        chk("force_waddr", {27'd0, bus.rf_waddr}, 32'd7);
        chk("force_wdata", bus.rf_wdata, 32'h7777);
`ifdef WB_ARB_PERF_EN
        chk("force_cnt", {16'd0, force_cnt}, 32'd1);
`endif
        chk("force_release", {31'd0, bus.stall_wb}, 32'd0);
        tick();
        chk("after_force_waddr", {27'd0, bus.rf_waddr}, 32'd3);
        chk("after_force_wdata", bus.rf_wdata, 32'h304);

        // WAW: pipeline write to r9 makes the buffered r9 stale.
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1111);
        tick();
        chk("waw_push_we", {31'd0, bus.rf_we}, 32'd0);
        drv(1'b1, 5'd9, 32'h2222, 1'b0, 5'd0, 32'd0);
        tick();
        chk("waw_wb_we", {31'd0, bus.rf_we}, 32'd1);
        chk("waw_wb_wdata", bus.rf_wdata, 32'h2222);
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("waw_stale_we", {31'd0, bus.rf_we}, 32'd0);
        tick();
        chk("waw_idle_we", {31'd0, bus.rf_we}, 32'd0);

        // Fill to full, then push and pop together on a full FIFO.
        drv(1'b1, 5'd3, 32'h30, 1'b1, 5'd10, 32'hA0);
        chk("fill0_ready", {31'd0, bus.md_ready}, 32'd1);
        tick();
        drv(1'b1, 5'd3, 32'h31, 1'b1, 5'd11, 32'hB0);
        chk("fill1_ready", {31'd0, bus.md_ready}, 32'd1);
        tick();
        drv(1'b1, 5'd3, 32'h32, 1'b1, 5'd12, 32'hC0);
        chk("full_ready", {31'd0, bus.md_ready}, 32'd0);
        tick();
        chk("full_wb_wdata", bus.rf_wdata, 32'h32);
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
        chk("full_pop_ready", {31'd0, bus.md_ready}, 32'd1);
        tick();
        chk("drain0_waddr", {27'd0, bus.rf_waddr}, 32'd10);
        chk("drain0_wdata", bus.rf_wdata, 32'hA0);
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("drain1_we", {31'd0, bus.rf_we}, 32'd1);
        chk("drain1_waddr", {27'd0, bus.rf_waddr}, 32'd11);
        tick();
        chk("drain2_we", {31'd0, bus.rf_we}, 32'd1);
        chk("drain2_waddr", {27'd0, bus.rf_waddr}, 32'd12);
        chk("drain2_wdata", bus.rf_wdata, 32'hC0);
        tick();
        chk("drain_done_we", {31'd0, bus.rf_we}, 32'd0);

        // Register 0 from either side is never written.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77);
            tick();
            chk("r0_we", {31'd0, bus.rf_we}, 32'd0);
        end
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("r0_drain_we", {31'd0, bus.rf_we}, 32'd0);

        // Reset mid-operation discards a buffered result.
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hEE);
        tick();
        rst_n = 1'b0;
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_we0", {31'd0, bus.rf_we}, 32'd0);
        tick();
        chk("midrst_we1", {31'd0, bus.rf_we}, 32'd0);

        // Three conflict cycles, then drain.
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'd3, 32'h40, 1'b0, 5'd0, 32'd0);
            tick();
        end
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("conf_drain_waddr", {27'd0, bus.rf_waddr}, 32'd13);
        chk("conf_drain_wdata", bus.rf_wdata, 32'hD0);
`ifdef WB_ARB_PERF_EN
        chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd3);
        chk("force_cnt_rst", {16'd0, force_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
